// File: rtl/mem_arbiter_if.sv
// Request-side and RAM-side signal bundle for mem_arbiter.
// master is the arbiter's view; slave is the requesters/RAM environment.
interface mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
    );

    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-RAM arbiter between instruction fetch and data access; data has
// priority, a saturating starvation counter forces a fetch after STARVE_MAX data completions.
module mem_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic          CLK,
    input  logic          nRST,
    mem_arbiter_if.master bus,
    output logic          bus_err
);
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;
    localparam logic [7:0] TLAST  = 8'(TIMEOUT - 1);
    localparam logic [2:0] SMAX   = 3'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_t;

    state_t      state, nextState;
    logic [7:0]  tCnt;
    logic [2:0]  sCnt;
    logic        dReq, sideReq, access, fault;

    assign dReq    = bus.dREN | bus.dWEN;
    assign sideReq = (state == IGRANT) ? bus.iREN : dReq;

    always_ff @(posedge CLK or negedge nRST) begin : stateReg
        if (!nRST) state <= IDLE;
        else       state <= nextState;
    end

    // access/fault are only meaningful inside a grant; a fault (bus error or
    // timeout) outranks a cancel in the same cycle.
    always_comb begin : nextStateLogic
        nextState = state;
        access    = 1'b0;
        fault     = 1'b0;
        unique case (state)
            IDLE: begin
                if (dReq && !(bus.iREN && sCnt == SMAX)) nextState = DGRANT;
                else if (bus.iREN)                       nextState = IGRANT;
            end
            IGRANT, DGRANT: begin
                access = (bus.ramstate == ACCESS);
                fault  = !access && (bus.ramstate == ERROR || tCnt == TLAST);
                if (access || fault || !sideReq) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin : counters
        if (!nRST) begin
            tCnt    <= '0;
            sCnt    <= '0;
            bus_err <= 1'b0;
        end else begin
            if (state == IDLE) tCnt <= '0;
            else if (!access)  tCnt <= tCnt + 8'd1;
            if (fault) bus_err <= 1'b1;
            if (!bus.iREN || (access && state == IGRANT))
                sCnt <= '0;
            else if (access && state == DGRANT && sCnt != SMAX)
                sCnt <= sCnt + 3'd1;
        end
    end

    always_comb begin : outputLogic
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iload    = bus.ramload;
        bus.dload    = bus.ramload;
        bus.iwait    = bus.iREN & ~(state == IGRANT && bus.ramstate == ACCESS);
        bus.dwait    = dReq     & ~(state == DGRANT && bus.ramstate == ACCESS);
        unique case (state)
            IGRANT: begin
                bus.ramREN  = bus.iREN;
                bus.ramaddr = bus.iaddr;
            end
            DGRANT: begin
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed test-plan steps followed by random traffic, all checked cycle by
// cycle against a transaction-level model of grant/starvation/error rules.
module tb_mem_arbiter;
    localparam int SMAX = 4;
    localparam int TOUT = 4;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;

    logic CLK = 1'b0;
    logic nRST;
    logic busErr;
    int   nChk = 0;
    int   nFail = 0;

    mem_arbiter_if bus ();
    mem_arbiter #(.STARVE_MAX(SMAX), .TIMEOUT(TOUT)) dut (
        .CLK(CLK), .nRST(nRST), .bus(bus.master), .bus_err(busErr)
    );

    always #5 CLK = ~CLK;

    // Model: who holds the grant (0 none, 1 fetch, 2 data), grant age,
    // data completions seen while a fetch waits, sticky error.
    int mGrant, mCyc, mStarve;
    bit mErr;
    bit rec = 1'b0;
    int grantLog[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChk++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic        eREN, eWEN, dreq, sideReq;
        logic [31:0] eAddr, eStore;
        @(negedge CLK);
        if (!nRST) begin
            mGrant = 0; mCyc = 0; mStarve = 0; mErr = 1'b0;
        end
        dreq = bus.dREN | bus.dWEN;
        eREN = 1'b0; eWEN = 1'b0; eAddr = '0; eStore = '0;
        if (mGrant == 1) begin
            eREN = bus.iREN; eAddr = bus.iaddr;
        end else if (mGrant == 2) begin
            eWEN = bus.dWEN; eREN = bus.dREN && !bus.dWEN;
            eAddr = bus.daddr; eStore = bus.dstore;
        end
        chk("ramREN",   bus.ramREN,   eREN);
        chk("ramWEN",   bus.ramWEN,   eWEN);
        chk("ramaddr",  bus.ramaddr,  eAddr);
        chk("ramstore", bus.ramstore, eStore);
        chk("iload",    bus.iload,    bus.ramload);
        chk("dload",    bus.dload,    bus.ramload);
        chk("iwait", bus.iwait, bus.iREN && !(mGrant == 1 && bus.ramstate == ACC));
        chk("dwait", bus.dwait, dreq && !(mGrant == 2 && bus.ramstate == ACC));
        chk("bus_err", busErr, mErr);
        if (rec && bus.ramREN) grantLog.push_back(bus.ramaddr == 32'h40 ? 1 : 2);
        if (nRST) begin
            if (mGrant == 0) begin
                mCyc = 0;
                if (dreq && !(bus.iREN && mStarve == SMAX)) mGrant = 2;
                else if (bus.iREN) mGrant = 1;
            end else begin
                sideReq = (mGrant == 1) ? bus.iREN : dreq;
                if (bus.ramstate == ACC) begin
                    if (mGrant == 1) mStarve = 0;
                    else if (bus.iREN && mStarve < SMAX) mStarve++;
                    mGrant = 0;
                end else if (bus.ramstate == ERR || mCyc + 1 == TOUT) begin
                    mErr = 1'b1; mGrant = 0;
                end else if (!sideReq) begin
                    mGrant = 0;
                end else begin
                    mCyc++;
                end
            end
            if (!bus.iREN) mStarve = 0;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic clearInputs();
        bus.iREN = 0; bus.dREN = 0; bus.dWEN = 0;
        bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
        bus.ramload = '0; bus.ramstate = BUSY;
    endtask

    task automatic doReset();
        nRST = 1'b0;
        clearInputs();
        step();
        nRST = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int expSeq[10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
        nRST = 1'b0;
        clearInputs();
        mGrant = 0; mCyc = 0; mStarve = 0; mErr = 1'b0;

        // Reset with both sides requesting
        bus.iREN = 1; bus.dREN = 1; bus.daddr = 32'h100;
        step(); step();
        chk("rst_iwait",  bus.iwait,  1'b1);
        chk("rst_dwait",  bus.dwait,  1'b1);
        chk("rst_ramREN", bus.ramREN, 1'b0);
        chk("rst_buserr", busErr,     1'b0);
        nRST = 1'b1;
        step();
        chk("rst_dgrant", bus.ramREN,  1'b1);
        chk("rst_daddr",  bus.ramaddr, 32'h100);
        bus.ramstate = ACC;
        step();

        // Single fetch completing in the third grant cycle
        doReset();
        bus.iREN = 1; bus.iaddr = 32'h40; bus.ramload = 32'h2408000A;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("fetch_wait", bus.iwait, 1'b1);
            if (k > 0) chk("fetch_addr", bus.ramaddr, 32'h40);
            step();
        end
        bus.ramstate = ACC;
        #1;
        chk("fetch_done_wait", bus.iwait,   1'b0);
        chk("fetch_iload",     bus.iload,   32'h2408000A);
        chk("fetch_addr",      bus.ramaddr, 32'h40);
        step();
        chk("fetch_idle", bus.ramREN, 1'b0);
        bus.iREN = 0; bus.ramstate = BUSY;
        step();

        // Priority and starvation
        doReset();
        bus.iREN = 1; bus.dREN = 1; bus.iaddr = 32'h40; bus.daddr = 32'h100;
        bus.ramstate = ACC;
        grantLog.delete();
        rec = 1'b1;
        repeat (20) step();
        rec = 1'b0;
        chk("starve_count", grantLog.size(), 10);
        for (int k = 0; k < 10 && k < grantLog.size(); k++)
            chk("starve_order", grantLog[k], expSeq[k]);

        // Write precedence, then bus error with re-grant
        doReset();
        bus.dREN = 1; bus.dWEN = 1; bus.daddr = 32'h100; bus.dstore = 32'hDEADBEEF;
        step();
        chk("wr_ramWEN",   bus.ramWEN,   1'b1);
        chk("wr_ramREN",   bus.ramREN,   1'b0);
        chk("wr_ramstore", bus.ramstore, 32'hDEADBEEF);
        chk("wr_ramaddr",  bus.ramaddr,  32'h100);
        bus.ramstate = ACC;
        step();
        bus.ramstate = BUSY;
        step();
        bus.ramstate = ERR;
        step();
        bus.ramstate = BUSY;
        #1;
        chk("err_flag",  busErr,    1'b1);
        chk("err_dwait", bus.dwait, 1'b1);
        step();
        chk("err_regrant", bus.ramWEN, 1'b1);
        bus.ramstate = ACC;
        step();
        bus.dREN = 0; bus.dWEN = 0;
        step();

        // Timeout with RAM stuck busy
        doReset();
        bus.iREN = 1; bus.iaddr = 32'h80;
        step();
        for (int k = 0; k < TOUT; k++) begin
            chk("to_grant", bus.ramREN, 1'b1);
            step();
        end
        chk("to_idle",   bus.ramREN, 1'b0);
        chk("to_buserr", busErr,     1'b1);
        bus.iREN = 0;
        step();

        // Cancel in the second fetch grant cycle
        doReset();
        bus.iREN = 1; bus.iaddr = 32'h44;
        step(); step();
        bus.iREN = 0;
        #1;
        chk("cancel_strobe", bus.ramREN, 1'b0);
        step();
        chk("cancel_buserr", busErr, 1'b0);
        step();

        // Random traffic with periodic mid-run resets
        doReset();
        for (int c = 0; c < 3000; c++) begin
            int r;
            if (c % 300 == 299) nRST = 1'b0;
            else nRST = 1'b1;
            bus.iREN   = ($urandom_range(0, 9) < 7);
            bus.dREN   = ($urandom_range(0, 9) < 6);
            bus.dWEN   = ($urandom_range(0, 9) < 3);
            bus.iaddr  = $urandom;
            bus.daddr  = $urandom;
            bus.dstore = $urandom;
            bus.ramload = $urandom;
            r = $urandom_range(0, 9);
            bus.ramstate = (r == 0) ? FREE : (r < 5) ? BUSY : (r < 9) ? ACC : ERR;
            step();
        end
        nRST = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
        $finish;
    end
endmodule
